// File: rtl/chol_wb_pkg.sv
// Shared types and sizing for the Cholesky lower-triangle writeback block.
// Optional read masking of upper/out-of-range elements: CHOL_WB_ZERO_UPPER_EN.
package chol_wb_pkg;

  localparam int LANES      = 4;
  localparam int LANE_W     = $clog2(LANES);
  localparam int IDX_W      = 6;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_N      = 32;
  localparam int BANK_DEPTH = (MAX_N / LANES) * MAX_N;
  localparam int BANK_AW    = $clog2(BANK_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DIAG,
    ST_COLLECT_LOWER,
    ST_DONE
  } state_e;

  // Element (r,c) lives in bank r mod LANES at word {r/LANES, c}.
  function automatic logic [LANE_W-1:0] bank_of(input logic [IDX_W-1:0] r);
    return LANE_W'(r % IDX_W'(LANES));
  endfunction

  function automatic logic [BANK_AW-1:0] bank_addr(input logic [IDX_W-1:0] r,
                                                   input logic [IDX_W-1:0] c);
    return BANK_AW'((int'(r) / LANES) * MAX_N + int'(c));
  endfunction

  // Length of the run of set bits starting at lane 0.
  function automatic logic [2:0] prefix_len(input logic [LANES-1:0] v);
    logic [2:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      run = run & v[k];
      n   = n + 3'(run);
    end
    return n;
  endfunction

endpackage

// File: rtl/chol_wb_bank.sv
// One bank of the lower-triangular store: one write port, one registered read port.
module chol_wb_bank
  import chol_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clock,
  input  logic               areset,
  input  logic               we,
  input  logic [BANK_AW-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic               re,
  input  logic [BANK_AW-1:0] raddr,
  output logic [DATA_W-1:0]  rdata
);

  logic [DATA_W-1:0] mem_q [BANK_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it can map onto RAM; contents survive areset.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Same-cycle read of a word being written sees the old word.
  always_ff @(posedge clock or posedge areset) begin
    if (areset)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/chol_lower_writeback.sv
// Collects Cholesky L[j][j] and up to LANES L[i][j] per cycle into a banked store.
// Define CHOL_WB_ZERO_UPPER_EN to read 0 for upper-triangle or out-of-range addresses.
module chol_lower_writeback
  import chol_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clock,
  input  logic                    areset,
  input  logic                    start,
  input  logic [IDX_W-1:0]        matrix_size,
  input  logic                    diag_valid,
  input  logic [DATA_W-1:0]       diag_data,
  input  logic [LANES-1:0]        lower_valid,
  input  logic [LANES*DATA_W-1:0] lower_data,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_row,
  input  logic [IDX_W-1:0]        rd_col,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    col_done,
  output logic [IDX_W-1:0]        cur_col,
  output logic                    done,
  output logic                    err_protocol
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  next_row_q, next_row_d;
  logic [IDX_W-1:0]  remain_q, remain_d;
  logic              col_done_q, col_done_d;
  logic              err_q, err_d;
  logic              rd_valid_q;
  logic [LANE_W-1:0] rd_sel_q;

  logic [2:0]        pc, acc;
  logic              contig;
  logic [IDX_W-1:0]  lane_row;
  logic [LANE_W-1:0] lane_bank;
  logic [LANES-1:0]  bank_we;
  logic [BANK_AW-1:0] bank_waddr [LANES];
  logic [DATA_W-1:0]  bank_wdata [LANES];
  logic [DATA_W-1:0]  bank_rdata [LANES];

  assign pc     = prefix_len(lower_valid);
  assign contig = (int'(pc) == $countones(lower_valid));
  assign acc    = (IDX_W'(pc) > remain_q) ? 3'(remain_q) : pc;

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      col_q      <= '0;
      next_row_q <= '0;
      remain_q   <= '0;
      col_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      col_q      <= col_d;
      next_row_q <= next_row_d;
      remain_q   <= remain_d;
      col_done_q <= col_done_d;
      err_q      <= err_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    col_d      = col_q;
    next_row_d = next_row_q;
    remain_d   = remain_q;
    col_done_d = 1'b0;
    err_d      = err_q;
    lane_row   = '0;
    lane_bank  = '0;
    bank_we    = '0;
    for (int b = 0; b < LANES; b++) begin
      bank_waddr[b] = '0;
      bank_wdata[b] = '0;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (matrix_size != '0 && int'(matrix_size) <= MAX_N) begin
            state_d = ST_WAIT_DIAG;
            n_d     = matrix_size;
            col_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_WAIT_DIAG: begin
        if (|lower_valid) err_d = 1'b1;
        if (diag_valid) begin
          lane_bank             = bank_of(col_q);
          bank_we[lane_bank]    = 1'b1;
          bank_waddr[lane_bank] = bank_addr(col_q, col_q);
          bank_wdata[lane_bank] = diag_data;
          next_row_d            = col_q + IDX_W'(1);
          remain_d              = n_q - IDX_W'(1) - col_q;
          if (remain_d == '0) begin
            col_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d    = ST_COLLECT_LOWER;
          end
        end
      end

      ST_COLLECT_LOWER: begin
        if (diag_valid || !contig || IDX_W'(pc) > remain_q) err_d = 1'b1;
        // Lane k targets row next_row+k; the bank rotates with next_row.
        for (int k = 0; k < LANES; k++) begin
          if (k < int'(acc)) begin
            lane_row              = next_row_q + IDX_W'(k);
            lane_bank             = bank_of(lane_row);
            bank_we[lane_bank]    = 1'b1;
            bank_waddr[lane_bank] = bank_addr(lane_row, col_q);
            bank_wdata[lane_bank] = lower_data[k*DATA_W +: DATA_W];
          end
        end
        next_row_d = next_row_q + IDX_W'(acc);
        remain_d   = remain_q - IDX_W'(acc);
        if (acc != '0 && remain_d == '0) begin
          col_done_d = 1'b1;
          col_d      = col_q + IDX_W'(1);
          state_d    = ST_WAIT_DIAG;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    chol_wb_bank #(.DATA_W(DATA_W)) u_bank (
      .clock (clock),
      .areset(areset),
      .we    (bank_we[b]),
      .waddr (bank_waddr[b]),
      .wdata (bank_wdata[b]),
      .re    (rd_en),
      .raddr (bank_addr(rd_row, rd_col)),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_sel_q <= bank_of(rd_row);
    end
  end

`ifdef CHOL_WB_ZERO_UPPER_EN
  logic rd_mask_q;

  always_ff @(posedge clock or posedge areset) begin
    if (areset)     rd_mask_q <= 1'b0;
    else if (rd_en) rd_mask_q <= (rd_col > rd_row) || (rd_row >= n_q);
  end

  assign rd_data = rd_mask_q ? '0 : bank_rdata[rd_sel_q];
`else
  assign rd_data = bank_rdata[rd_sel_q];
`endif

  assign rd_valid     = rd_valid_q;
  assign busy         = (state_q == ST_WAIT_DIAG) || (state_q == ST_COLLECT_LOWER);
  assign done         = (state_q == ST_DONE);
  assign col_done     = col_done_q;
  assign cur_col      = col_q;
  assign err_protocol = err_q;

endmodule

// File: tb/tb_chol_lower_writeback.sv
// Directed bench for chol_lower_writeback with hand-computed expected values.
module tb_chol_lower_writeback;

  logic         clock;
  logic         areset;
  logic         start;
  logic [5:0]   matrix_size;
  logic         diag_valid;
  logic [31:0]  diag_data;
  logic [3:0]   lower_valid;
  logic [127:0] lower_data;
  logic         rd_en;
  logic [5:0]   rd_row;
  logic [5:0]   rd_col;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         busy;
  logic         col_done;
  logic [5:0]   cur_col;
  logic         done;
  logic         err_protocol;

  int vectors;
  int fails;
  int col_done_cnt;

  chol_lower_writeback dut (
    .clock       (clock),
    .areset      (areset),
    .start       (start),
    .matrix_size (matrix_size),
    .diag_valid  (diag_valid),
    .diag_data   (diag_data),
    .lower_valid (lower_valid),
    .lower_data  (lower_data),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .busy        (busy),
    .col_done    (col_done),
    .cur_col     (cur_col),
    .done        (done),
    .err_protocol(err_protocol)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (col_done === 1'b1) col_done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    start       = 1'b0;
    diag_valid  = 1'b0;
    lower_valid = '0;
    rd_en       = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] n);
    start       = 1'b1;
    matrix_size = n;
    cycle();
  endtask

  task automatic diag(input logic [31:0] d);
    diag_valid = 1'b1;
    diag_data  = d;
    cycle();
  endtask

  task automatic lower(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    lower_valid = v;
    lower_data  = {d3, d2, d1, d0};
    cycle();
  endtask

  task automatic rd(input logic [5:0] r, input logic [5:0] c);
    rd_en  = 1'b1;
    rd_row = r;
    rd_col = c;
    cycle();
  endtask

  initial begin
    vectors      = 0;
    fails        = 0;
    col_done_cnt = 0;
    areset       = 1'b1;
    start        = 1'b0;
    matrix_size  = '0;
    diag_valid   = 1'b0;
    diag_data    = '0;
    lower_valid  = '0;
    lower_data   = '0;
    rd_en        = 1'b0;
    rd_row       = '0;
    rd_col       = '0;
    repeat (2) @(posedge clock);
    #1 areset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_col_done", 32'(col_done), 32'd0);
    check("rst_err", 32'(err_protocol), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_cur_col", 32'(cur_col), 32'd0);

    // N=1
    do_start(6'd1);
    check("n1_busy", 32'(busy), 32'd1);
    check("n1_done_low", 32'(done), 32'd0);
    diag(32'h100);
    check("n1_col_done", 32'(col_done), 32'd1);
    check("n1_done", 32'(done), 32'd1);
    check("n1_busy_low", 32'(busy), 32'd0);
    cycle();
    check("n1_col_done_pulse", 32'(col_done), 32'd0);
    check("n1_done_held", 32'(done), 32'd1);
    rd(6'd0, 6'd0);
    check("n1_rd_valid", 32'(rd_valid), 32'd1);
    check("n1_rd_00", rd_data, 32'h100);
    cycle();
    check("n1_rd_valid_low", 32'(rd_valid), 32'd0);

    // N=6: 4+1 split, bank rotation, overfull beat on column 3
    do_start(6'd6);
    check("n6_busy", 32'(busy), 32'd1);
    diag(32'h600);
    lower(4'b1111, 32'h610, 32'h620, 32'h630, 32'h640);
    check("n6_c0_mid", 32'(col_done), 32'd0);
    lower(4'b0001, 32'h650, 32'h0, 32'h0, 32'h0);
    check("n6_c0_done", 32'(col_done), 32'd1);
    check("n6_c0_next", 32'(cur_col), 32'd1);
    check("n6_c0_err", 32'(err_protocol), 32'd0);
    diag(32'h611);
    lower(4'b1111, 32'h621, 32'h631, 32'h641, 32'h651);
    check("n6_c1_done", 32'(col_done), 32'd1);
    check("n6_c1_next", 32'(cur_col), 32'd2);
    diag(32'h622);
    lower(4'b0111, 32'h632, 32'h642, 32'h652, 32'h0);
    check("n6_c2_next", 32'(cur_col), 32'd3);
    diag(32'h633);
    lower(4'b1111, 32'h643, 32'h653, 32'hdead, 32'hbeef);
    check("n6_c3_done", 32'(col_done), 32'd1);
    check("n6_c3_err", 32'(err_protocol), 32'd1);
    check("n6_c3_next", 32'(cur_col), 32'd4);
    diag(32'h644);
    lower(4'b0001, 32'h654, 32'h0, 32'h0, 32'h0);
    diag(32'h655);
    check("n6_done", 32'(done), 32'd1);
    check("n6_last_col_done", 32'(col_done), 32'd1);
    check("n6_busy_low", 32'(busy), 32'd0);
    check("n6_err_sticky", 32'(err_protocol), 32'd1);
    rd(6'd5, 6'd0);
    check("n6_rd_50", rd_data, 32'h650);
    rd(6'd5, 6'd1);
    check("n6_rd_51", rd_data, 32'h651);
    rd(6'd4, 6'd1);
    check("n6_rd_41", rd_data, 32'h641);
    rd(6'd4, 6'd3);
    check("n6_rd_43", rd_data, 32'h643);
    rd(6'd5, 6'd3);
    check("n6_rd_53", rd_data, 32'h653);
    rd(6'd5, 6'd5);
    check("n6_rd_55", rd_data, 32'h655);

    // Invalid sizes from DONE
    do_start(6'd0);
    check("bad0_err", 32'(err_protocol), 32'd1);
    check("bad0_done", 32'(done), 32'd1);
    do_start(6'd33);
    check("bad33_busy", 32'(busy), 32'd0);
    check("bad33_err", 32'(err_protocol), 32'd1);

    // N=4 full beats
    do_start(6'd4);
    col_done_cnt = 0;
    check("n4_err_clr", 32'(err_protocol), 32'd0);
    check("n4_done_clr", 32'(done), 32'd0);
    diag(32'h400);
    lower(4'b0111, 32'h410, 32'h420, 32'h430, 32'h0);
    check("n4_c0_next", 32'(cur_col), 32'd1);
    diag(32'h411);
    lower(4'b0011, 32'h421, 32'h431, 32'h0, 32'h0);
    check("n4_c1_next", 32'(cur_col), 32'd2);
    diag(32'h422);
    lower(4'b0001, 32'h432, 32'h0, 32'h0, 32'h0);
    diag(32'h433);
    check("n4_done", 32'(done), 32'd1);
    check("n4_err", 32'(err_protocol), 32'd0);
    cycle();
    check("n4_col_done_cnt", 32'(col_done_cnt), 32'd4);
    rd(6'd3, 6'd1);
    check("n4_rd_31", rd_data, 32'h431);
    rd(6'd2, 6'd0);
    check("n4_rd_20", rd_data, 32'h420);
    rd(6'd3, 6'd3);
    check("n4_rd_33", rd_data, 32'h433);
    rd(6'd1, 6'd3);
    check("n4_rd_13_valid", 32'(rd_valid), 32'd1);
`ifdef CHOL_WB_ZERO_UPPER_EN
    check("n4_rd_13_masked", rd_data, 32'd0);
`endif
    rd(6'd5, 6'd0);
`ifdef CHOL_WB_ZERO_UPPER_EN
    check("n4_rd_50_masked", rd_data, 32'd0);
`else
    check("n4_rd_50_stale", rd_data, 32'h650);
`endif

    // Reset mid-matrix in COLLECT_LOWER of column 2
    do_start(6'd6);
    diag(32'h700);
    lower(4'b1111, 32'h710, 32'h720, 32'h730, 32'h740);
    lower(4'b0011, 32'h750, 32'hbad, 32'h0, 32'h0);
    check("rs_err", 32'(err_protocol), 32'd1);
    diag(32'h711);
    lower(4'b1111, 32'h721, 32'h731, 32'h741, 32'h751);
    diag(32'h722);
    lower(4'b0001, 32'h732, 32'h0, 32'h0, 32'h0);
    check("rs_cur_col", 32'(cur_col), 32'd2);
    check("rs_busy", 32'(busy), 32'd1);
    areset = 1'b1;
    #2;
    check("rs_busy_low", 32'(busy), 32'd0);
    check("rs_err_low", 32'(err_protocol), 32'd0);
    check("rs_cur_col_zero", 32'(cur_col), 32'd0);
    @(negedge clock);
    areset = 1'b0;

    // N=3 after reset
    do_start(6'd3);
    check("n3_busy", 32'(busy), 32'd1);
    diag(32'h800);
    lower(4'b0011, 32'h810, 32'h820, 32'h0, 32'h0);
    diag(32'h811);
    lower(4'b0001, 32'h821, 32'h0, 32'h0, 32'h0);
    diag(32'h822);
    check("n3_done", 32'(done), 32'd1);
    check("n3_err", 32'(err_protocol), 32'd0);
    rd(6'd2, 6'd1);
    check("n3_rd_21", rd_data, 32'h821);
    rd(6'd2, 6'd0);
    check("n3_rd_20", rd_data, 32'h820);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/chol_lower_writeback.md
# chol_lower_writeback

Downstream result collector for the Cholesky stage of the UKF accelerator. Accepts diagonal elements L[j][j] and up to four lower elements L[i][j] per cycle from the diag/lower datapath, and writes them into a banked lower-triangular store. Tracks column progress, signals column and matrix completion, and exposes a one-cycle-latency random read port for the downstream prediction/update stages.

## Interface
- DATA_W, 32, element width (fixed-point word from the sqrt/divider pipeline)
- MAX_N, 32, maximum matrix dimension; row/col indices are 6 bits
- LANES, 4, parallel lower-element lanes; equals the bank count
- clock  in  1  single clock, all state on rising edge
- areset  in  1  asynchronous, active-high reset
- start  in  1  pulse; latches matrix_size and begins a new matrix
- matrix_size  in  6  N, 1..MAX_N
- diag_valid  in  1  diag_data carries L[j][j] for current column j
- diag_data  in  DATA_W  diagonal element
- lower_valid  in  LANES  lane k valid; must be contiguous from bit 0
- lower_data  in  LANES*DATA_W  lane k at bits [k*DATA_W +: DATA_W]
- rd_en  in  1  read request
- rd_row, rd_col  in  6  read address
- rd_data  out  DATA_W  read result
- rd_valid  out  1  rd_data valid
- busy  out  1  matrix in progress
- col_done  out  1  one-cycle pulse when column j fully written
- cur_col  out  6  column currently being collected
- done  out  1  held high after last element written, until next start
- err_protocol  out  1  sticky; cleared by start or reset

## Operation
- FSM states: IDLE, WAIT_DIAG, COLLECT_LOWER, DONE.
- IDLE/DONE: start with 1 <= matrix_size <= MAX_N -> latch N, cur_col=0, clear done and err_protocol, go WAIT_DIAG. Invalid size -> err_protocol=1, stay in IDLE/DONE. start while busy is ignored.
- WAIT_DIAG: diag_valid writes L[j][j]; next_row=j+1, remain=N-1-j. remain==0 (j==N-1) -> col_done, go DONE. Otherwise go COLLECT_LOWER. Any lower_valid bit in WAIT_DIAG -> err_protocol, lanes dropped; diag still accepted if valid.
- COLLECT_LOWER: lane k writes row next_row+k, column j, for k < popcount(lower_valid). Accepted count = min(popcount, remain). Lanes beyond remain, non-contiguous valid, or diag_valid -> err_protocol, offending data dropped. next_row and remain advance by accepted count. remain reaching 0 -> col_done, cur_col+1, go WAIT_DIAG.
- Banking: element (r,c) lives in bank r mod LANES, address {r/LANES, c}. Consecutive rows hit distinct banks, so one write per bank per cycle. Lane-to-bank rotation by next_row mod LANES.
- Read: bank rd_row mod LANES, registered output. Reads are allowed in any state. A read of an address written in the same cycle returns the old data.
- Widths: remain and next_row are 6 bits, with no wrap since N <= MAX_N. Popcount is 3 bits.

## Timing
- Reset: state=IDLE. busy, col_done, done, err_protocol, rd_valid=0. rd_data=0, cur_col=0. Store contents are not cleared.
- Reset mid-matrix: immediate return to IDLE, partial results abandoned.
- Write latency: an element accepted at edge t is readable by a rd_en at t+1, with data at t+2.
- col_done and done assert on the edge after the final element of the column or matrix is accepted. done and busy are mutually exclusive.
- busy is high from the edge after a valid start until the edge done rises.
- Read latency: exactly 1 cycle. rd_valid = registered rd_en.

## Configuration
- CHOL_WB_ZERO_UPPER_EN defined: reads with rd_col > rd_row or rd_row >= N return 0 with rd_valid=1. Comparison uses the latched N.
- Not defined: no masking. Those reads return raw bank contents, which may be stale.

## Structure
- Package chol_wb_pkg: state enum, LANES, index width (6), DATA_W default, bank address width.
- Sub-module chol_wb_bank: single write port, single registered read port. Depth (MAX_N/LANES)*MAX_N. Instantiated LANES times.

## Test plan
- N=1: start, diag_valid with 0x100 -> col_done and done one cycle later; read (0,0) = 0x100.
- N=4, full beats: per column, diag then lanes 3/2/1 valid -> 10 elements stored, 4 col_done pulses, read (3,1) returns the written value.
- N=6, column 0 lowers delivered as 4+1 lanes -> next_row=5 then 6, transition to WAIT_DIAG, banks rotate correctly (row 5 in bank 1).
- lower_valid=4'b1111 with remain=2 -> rows j+1 and j+2 written, err_protocol=1, column completes.
- areset asserted in COLLECT_LOWER of column 2 -> IDLE, busy=0. New start with N=3 completes cleanly and err_protocol=0.
- With CHOL_WB_ZERO_UPPER_EN, read (1,3) after N=4 -> rd_data=0, rd_valid=1. Without the macro, stale contents are returned.
